// File: rtl/data_counter_seeker_if.sv
// Request/status handshake plus the drive and readback lines of the data counter.
interface data_counter_seeker_if;
    logic       req;
    logic [9:0] target;
    logic [9:0] cnt_value;
    logic       busy;
    logic       done;
    logic       err;
    logic       step;
    logic       reverse;
    logic       set;
    logic [9:0] set_value;

    modport master (
        output req, target, cnt_value,
        input  busy, done, err, step, reverse, set, set_value
    );

    modport slave (
        input  req, target, cnt_value,
        output busy, done, err, step, reverse, set, set_value
    );
endinterface

// File: rtl/data_counter_seeker.sv
// Walks the BCD data counter to a target by the shorter way round the 0..255 ring; each step costs 2+PULSE_W+GAP_W clocks.
// Req is only sampled while idle; optional DIRECT_SET_EN loads far targets with a single Set strobe.
module data_counter_seeker #(
    parameter int PULSE_W       = 4,
    parameter int GAP_W         = 4,
    parameter int STEP_LIMIT    = 130,
    parameter int SET_THRESHOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_counter_seeker_if.slave bus
);
    localparam int TMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = $clog2(STEP_LIMIT + 1);

    if (PULSE_W < 1 || GAP_W < 1 || STEP_LIMIT < 1 || SET_THRESHOLD < 0) begin : g_bad_param
        $error("data_counter_seeker: illegal parameter value");
    end

    typedef enum logic [2:0] {IDLE, CHECK, SETUP, PULSE, GAP} state_t;

    state_t        state_q, state_d;
    logic [9:0]    tgt_q, tgt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic          step_q, step_d, rev_q, rev_d;

    function automatic logic [8:0] bcd_bin(input logic [9:0] v);
        return 9'(v[9:8]) * 9'd100 + 9'(v[7:4]) * 9'd10 + 9'(v[3:0]);
    endfunction

    function automatic logic bcd_ok(input logic [9:0] v);
        return (v[9:8] <= 2'd2) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bcd_bin(v) <= 9'd255);
    endfunction

    logic [8:0] t_bin, c_bin;
    logic       t_ok, c_ok;
    logic [7:0] fwd;

    assign t_bin = bcd_bin(tgt_q);
    assign c_bin = bcd_bin(bus.cnt_value);
    assign t_ok  = bcd_ok(tgt_q);
    assign c_ok  = bcd_ok(bus.cnt_value);
    // Both values are proven <= 255 before fwd is used, so 8-bit wrap gives (t - c) mod 256.
    assign fwd   = t_bin[7:0] - c_bin[7:0];

`ifdef DIRECT_SET_EN
    logic       set_q, set_d, first_q, first_d;
    logic [9:0] setv_q, setv_d;
    logic [7:0] dist;

    assign dist = (fwd > 8'd128) ? 8'(9'd256 - {1'b0, fwd}) : fwd;
`endif

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        step_d  = step_q;
        rev_d   = rev_q;
`ifdef DIRECT_SET_EN
        set_d   = set_q;
        setv_d  = setv_q;
        first_d = first_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    tgt_d   = bus.target;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CHECK;
`ifdef DIRECT_SET_EN
                    first_d = 1'b1;
`endif
                end
            end
            CHECK: begin
`ifdef DIRECT_SET_EN
                first_d = 1'b0;
`endif
                if (!t_ok || !c_ok) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (c_bin == t_bin) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == CW'(STEP_LIMIT)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef DIRECT_SET_EN
                end else if (first_q && (int'(dist) > SET_THRESHOLD)) begin
                    // Set reuses the PULSE/GAP timing but never counts as a step.
                    set_d   = 1'b1;
                    setv_d  = tgt_q;
                    tmr_d   = '0;
                    state_d = PULSE;
`endif
                end else begin
                    rev_d   = (fwd > 8'd128);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                step_d  = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                tmr_d   = '0;
                state_d = PULSE;
            end
            PULSE: begin
                if (tmr_q == TW'(PULSE_W - 1)) begin
                    step_d  = 1'b0;
`ifdef DIRECT_SET_EN
                    set_d   = 1'b0;
                    setv_d  = '0;
`endif
                    tmr_d   = '0;
                    state_d = GAP;
                end else begin
                    tmr_d   = tmr_q + TW'(1);
                end
            end
            GAP: begin
                if (tmr_q == TW'(GAP_W - 1)) begin
                    tmr_d   = '0;
                    state_d = CHECK;
                end else begin
                    tmr_d   = tmr_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            tmr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            step_q  <= 1'b0;
            rev_q   <= 1'b0;
`ifdef DIRECT_SET_EN
            set_q   <= 1'b0;
            setv_q  <= '0;
            first_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            step_q  <= step_d;
            rev_q   <= rev_d;
`ifdef DIRECT_SET_EN
            set_q   <= set_d;
            setv_q  <= setv_d;
            first_q <= first_d;
`endif
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.step    = step_q;
    assign bus.reverse = rev_q;
`ifdef DIRECT_SET_EN
    assign bus.set       = set_q;
    assign bus.set_value = setv_q;
`else
    assign bus.set       = 1'b0;
    assign bus.set_value = '0;
`endif
endmodule

// File: tb/tb_data_counter_seeker.sv
// Drives data_counter_seeker against a behavioural dekatron counter and a ring-distance reference model.
module tb_data_counter_seeker;
    localparam int PULSE_W = 4, GAP_W = 4, STEP_LIMIT = 130, SET_THRESHOLD = 16;
    localparam int STEP_CLKS = PULSE_W + GAP_W + 2;
    localparam int SET_CLKS  = PULSE_W + GAP_W + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    data_counter_seeker_if bus();

    data_counter_seeker #(
        .PULSE_W(PULSE_W), .GAP_W(GAP_W), .STEP_LIMIT(STEP_LIMIT), .SET_THRESHOLD(SET_THRESHOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [9:0] bin2bcd(input int v);
        logic [9:0] r;
        r[9:8] = 2'(v / 100);
        r[7:4] = 4'((v / 10) % 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int bcd2bin(input logic [9:0] v);
        return int'(v[9:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit bcd_valid(input logic [9:0] v);
        return (int'(v[9:8]) <= 2) && (int'(v[7:4]) <= 9) && (int'(v[3:0]) <= 9) && (bcd2bin(v) <= 255);
    endfunction

    function automatic int fwd_of(input int c, input int t);
        return (t - c + 256) % 256;
    endfunction

    function automatic int dist_of(input int c, input int t);
        return (fwd_of(c, t) > 128) ? 256 - fwd_of(c, t) : fwd_of(c, t);
    endfunction

    function automatic bit use_set(input int c, input int t);
`ifdef DIRECT_SET_EN
        return dist_of(c, t) > SET_THRESHOLD;
`else
        return (c < 0) && (t < 0);
`endif
    endfunction

    // ---------------- counter model and pulse monitor ----------------
    int         cnt_model = 0;
    bit         frozen = 1'b0;
    int         force_val = 0;
    int         force_seq = 0;
    int         force_seen = 0;
    int         pulses_total = 0;
    int         sets_total = 0;
    int         width_bad = 0;
    int         rev_flips = 0;
    int         high_len = 0;
    logic       step_prev = 1'b0, set_prev = 1'b0, rev_prev = 1'b0;
    logic       last_rev = 1'b0;
    logic [9:0] last_setv = '0;

    assign bus.cnt_value = bin2bcd(cnt_model);

    always @(negedge clk) begin
        step_prev <= bus.step;
        set_prev  <= bus.set;
        rev_prev  <= bus.reverse;
        if (force_seq != force_seen) begin
            force_seen <= force_seq;
            cnt_model  <= force_val;
        end else if (bus.step && !step_prev) begin
            pulses_total <= pulses_total + 1;
            last_rev     <= bus.reverse;
            if (!frozen) cnt_model <= bus.reverse ? (cnt_model + 255) % 256 : (cnt_model + 1) % 256;
        end else if (bus.set && !set_prev) begin
            sets_total <= sets_total + 1;
            last_setv  <= bus.set_value;
            cnt_model  <= bcd2bin(bus.set_value);
        end
        if (bus.step || bus.set) begin
            high_len <= high_len + 1;
        end else if (step_prev || set_prev) begin
            if (high_len != PULSE_W) width_bad <= width_bad + 1;
            high_len <= 0;
        end
        // Direction must already be settled when Step rises and must not move while it is high.
        if (bus.step && (bus.reverse !== rev_prev)) rev_flips <= rev_flips + 1;
    end

    task automatic set_counter(input int v);
        force_val = v;
        force_seq = force_seq + 1;
        repeat (2) @(negedge clk);
    endtask

    // Issues one request and reports what happened; callers do the comparing.
    task automatic run_op(input logic [9:0] tgt, input bit hold,
                          output int n, output bit got_done, output bit got_err,
                          output bit busy_end, output bit busy_next,
                          output int d_pulses, output int d_sets, output int d_width, output int d_flips);
        int p0, s0, w0, f0;
        p0 = pulses_total; s0 = sets_total; w0 = width_bad; f0 = rev_flips;
        n = 0; got_done = 0; got_err = 0; busy_end = 1'b1;
        bus.req = 1'b1;
        bus.target = tgt;
        for (int k = 1; k <= 4000; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) bus.req = 1'b0;
            if (bus.done || bus.err) begin
                n = k; got_done = bus.done; got_err = bus.err; busy_end = bus.busy;
                break;
            end
        end
        @(negedge clk);
        busy_next = bus.busy;
        d_pulses = pulses_total - p0;
        d_sets   = sets_total - s0;
        d_width  = width_bad - w0;
        d_flips  = rev_flips - f0;
    endtask

    int n, dp, ds, dw, df;
    bit gd, ge, be, bn;

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.req = 1'b0; bus.target = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", bus.err); end
        checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL reset_step: got %0b want 0", bus.step); end
        checks++; if (bus.reverse !== 1'b0) begin errors++; $display("FAIL reset_reverse: got %0b want 0", bus.reverse); end
        checks++; if (bus.set !== 1'b0) begin errors++; $display("FAIL reset_set: got %0b want 0", bus.set); end
        checks++; if (bus.set_value !== 10'h000) begin errors++; $display("FAIL reset_set_value: got %h want 000", bus.set_value); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_step_forward();
        set_counter(0);
        run_op(10'h005, 1'b0, n, gd, ge, be, bn, dp, ds, dw, df);
        checks++; if (gd !== 1'b1 || ge !== 1'b0) begin errors++; $display("FAIL fwd5_outcome: got done=%0b err=%0b want done=1 err=0", gd, ge); end
        checks++; if (dp != 5) begin errors++; $display("FAIL fwd5_pulses: got %0d want 5", dp); end
        checks++; if (last_rev !== 1'b0) begin errors++; $display("FAIL fwd5_reverse: got %0b want 0", last_rev); end
        checks++; if (dw != 0) begin errors++; $display("FAIL fwd5_width: got %0d bad pulses want 0", dw); end
        checks++; if (n != 2 + 5 * STEP_CLKS) begin errors++; $display("FAIL fwd5_latency: got %0d want %0d", n, 2 + 5 * STEP_CLKS); end
        checks++; if (be !== 1'b0) begin errors++; $display("FAIL fwd5_busy: got %0b want 0", be); end
        checks++; if (cnt_model != 5) begin errors++; $display("FAIL fwd5_counter: got %0d want 5", cnt_model); end
        checks++; if (df != 0) begin errors++; $display("FAIL fwd5_rev_stable: got %0d changes want 0", df); end
    endtask

    task automatic test_wrap_reverse();
        set_counter(10);
        run_op(10'h250, 1'b0, n, gd, ge, be, bn, dp, ds, dw, df);
        checks++; if (gd !== 1'b1 || ge !== 1'b0) begin errors++; $display("FAIL wrap_outcome: got done=%0b err=%0b want done=1 err=0", gd, ge); end
        checks++; if (dp != 16) begin errors++; $display("FAIL wrap_pulses: got %0d want 16", dp); end
        checks++; if (last_rev !== 1'b1) begin errors++; $display("FAIL wrap_reverse: got %0b want 1", last_rev); end
        checks++; if (cnt_model != 250) begin errors++; $display("FAIL wrap_counter: got %0d want 250", cnt_model); end
        checks++; if (df != 0) begin errors++; $display("FAIL wrap_rev_stable: got %0d changes want 0", df); end
    endtask

    task automatic test_tie();
        set_counter(0);
        run_op(10'h128, 1'b0, n, gd, ge, be, bn, dp, ds, dw, df);
        checks++; if (gd !== 1'b1) begin errors++; $display("FAIL tie_done: got %0b want 1", gd); end
        checks++; if (dp != (use_set(0, 128) ? 0 : 128)) begin errors++; $display("FAIL tie_pulses: got %0d want %0d", dp, use_set(0, 128) ? 0 : 128); end
        checks++; if (cnt_model != 128) begin errors++; $display("FAIL tie_counter: got %0d want 128", cnt_model); end
`ifndef DIRECT_SET_EN
        checks++; if (last_rev !== 1'b0) begin errors++; $display("FAIL tie_reverse: got %0b want 0", last_rev); end
`endif
    endtask

    task automatic test_invalid();
        logic [9:0] bad [2];
        bad[0] = 10'h260;
        bad[1] = 10'h0A5;
        set_counter(0);
        for (int i = 0; i < 2; i++) begin
            run_op(bad[i], 1'b0, n, gd, ge, be, bn, dp, ds, dw, df);
            checks++; if (ge !== 1'b1 || gd !== 1'b0) begin errors++; $display("FAIL invalid_%h_outcome: got done=%0b err=%0b want err only", bad[i], gd, ge); end
            checks++; if (n != 2) begin errors++; $display("FAIL invalid_%h_latency: got %0d want 2", bad[i], n); end
            checks++; if (dp != 0 || ds != 0) begin errors++; $display("FAIL invalid_%h_moves: got steps=%0d sets=%0d want 0", bad[i], dp, ds); end
            checks++; if (be !== 1'b0) begin errors++; $display("FAIL invalid_%h_busy: got %0b want 0", bad[i], be); end
        end
    endtask

    task automatic test_step_limit();
        set_counter(3);
        frozen = 1'b1;
        run_op(10'h009, 1'b0, n, gd, ge, be, bn, dp, ds, dw, df);
        frozen = 1'b0;
        checks++; if (ge !== 1'b1 || gd !== 1'b0) begin errors++; $display("FAIL limit_outcome: got done=%0b err=%0b want err only", gd, ge); end
        checks++; if (dp != STEP_LIMIT) begin errors++; $display("FAIL limit_pulses: got %0d want %0d", dp, STEP_LIMIT); end
        checks++; if (n != 2 + STEP_LIMIT * STEP_CLKS) begin errors++; $display("FAIL limit_latency: got %0d want %0d", n, 2 + STEP_LIMIT * STEP_CLKS); end
    endtask

    task automatic test_reset_mid_pulse();
        int k;
        set_counter(20);
        bus.req = 1'b1; bus.target = 10'h015;
        @(negedge clk);
        bus.req = 1'b0;
        for (k = 0; k < 100 && bus.step !== 1'b1; k++) @(negedge clk);
        checks++; if (bus.step !== 1'b1 || bus.reverse !== 1'b1) begin errors++; $display("FAIL midrst_pre: got step=%0b rev=%0b want 1 1", bus.step, bus.reverse); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL midrst_step: got %0b want 0", bus.step); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.reverse !== 1'b0) begin errors++; $display("FAIL midrst_reverse: got %0b want 0", bus.reverse); end
        rst_n = 1'b1;
        set_counter(7);
        run_op(10'h007, 1'b0, n, gd, ge, be, bn, dp, ds, dw, df);
        checks++; if (gd !== 1'b1 || n != 2) begin errors++; $display("FAIL midrst_at_target: got done=%0b after %0d want done after 2", gd, n); end
        checks++; if (dp != 0 || ds != 0) begin errors++; $display("FAIL midrst_moves: got steps=%0d sets=%0d want 0", dp, ds); end
    endtask

    task automatic test_back_to_back();
        set_counter(40);
        run_op(10'h040, 1'b1, n, gd, ge, be, bn, dp, ds, dw, df);
        bus.req = 1'b0;
        checks++; if (gd !== 1'b1 || n != 2) begin errors++; $display("FAIL b2b_first: got done=%0b after %0d want done after 2", gd, n); end
        checks++; if (bn !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy: got %0b want 1", bn); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %0b want 1", bus.done); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int c, t, ep, es;
        logic [9:0] tgt;
        for (int i = 0; i < 10; i++) begin
            c = cnt_model;
            if ($urandom_range(0, 4) == 0) tgt = 10'($urandom_range(0, 1023));
            else tgt = bin2bcd(int'($urandom_range(0, 255)));
            run_op(tgt, 1'b0, n, gd, ge, be, bn, dp, ds, dw, df);
            if (!bcd_valid(tgt)) begin
                checks++; if (ge !== 1'b1 || gd !== 1'b0 || n != 2 || dp != 0) begin errors++; $display("FAIL rand%0d_invalid_%h: got done=%0b err=%0b n=%0d steps=%0d want err at 2, no steps", i, tgt, gd, ge, n, dp); end
            end else begin
                t  = bcd2bin(tgt);
                es = use_set(c, t) ? 1 : 0;
                ep = es ? 0 : dist_of(c, t);
                checks++; if (gd !== 1'b1 || ge !== 1'b0) begin errors++; $display("FAIL rand%0d_outcome %0d->%0d: got done=%0b err=%0b want done", i, c, t, gd, ge); end
                checks++; if (dp != ep || ds != es) begin errors++; $display("FAIL rand%0d_moves %0d->%0d: got steps=%0d sets=%0d want %0d %0d", i, c, t, dp, ds, ep, es); end
                checks++; if (cnt_model != t) begin errors++; $display("FAIL rand%0d_counter: got %0d want %0d", i, cnt_model, t); end
                checks++; if (n != 2 + ep * STEP_CLKS + es * SET_CLKS) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", i, n, 2 + ep * STEP_CLKS + es * SET_CLKS); end
                checks++; if (dw != 0 || df != 0) begin errors++; $display("FAIL rand%0d_pulse_shape: got width_bad=%0d rev_changes=%0d want 0 0", i, dw, df); end
            end
        end
    endtask

`ifdef DIRECT_SET_EN
    task automatic test_direct_set();
        set_counter(0);
        run_op(10'h200, 1'b0, n, gd, ge, be, bn, dp, ds, dw, df);
        checks++; if (ds != 1 || dp != 0) begin errors++; $display("FAIL dset_moves: got sets=%0d steps=%0d want 1 0", ds, dp); end
        checks++; if (last_setv !== 10'h200) begin errors++; $display("FAIL dset_value: got %h want 200", last_setv); end
        checks++; if (gd !== 1'b1 || cnt_model != 200) begin errors++; $display("FAIL dset_done: got done=%0b cnt=%0d want 1 200", gd, cnt_model); end
    endtask
`endif

    initial begin
        test_reset();
        test_step_forward();
        test_wrap_reverse();
        test_tie();
        test_invalid();
        test_step_limit();
        test_reset_mid_pulse();
        test_back_to_back();
        test_random();
`ifdef DIRECT_SET_EN
        test_direct_set();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_counter_seeker.md
Name: data_counter_seeker

Overview:
- Drives the three-dekatron data counter (range 0..255, BCD readback) from its current value to a requested target value.
- Issues Step/Reverse pulses and re-reads the counter's 8-4-2-1 output after every step.
- Sits between the control sequencer and the data counter; the counter's Step/Reverse/Set inputs connect to this block's outputs.
- Picks the shorter direction around the 0..255 ring. The counter's limit logic handles the 255<->0 wrap.

Parameters:
- PULSE_W, 4: Step high time in clocks (>=1).
- GAP_W, 4: Step low settle time in clocks before readback (>=1).
- STEP_LIMIT, 130: maximum pulses per request before error.
- SET_THRESHOLD, 16: distance above which a direct Set is used (only with DIRECT_SET_EN).

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Rst_n  in  1  synchronous, active-low reset.
- Req  in  1  start request, sampled in IDLE only.
- Target  in  10  target value, BCD: [9:8] hundreds, [7:4] tens, [3:0] ones.
- CntValue  in  10  counter readback, same BCD format.
- Busy  out  1  high from accepted Req until Done/Err.
- Done  out  1  one-clock pulse: counter equals target.
- Err  out  1  one-clock pulse: invalid BCD or step limit exceeded.
- Step  out  1  step pulse to counter.
- Reverse  out  1  direction to counter: 1 = decrement.
- Set  out  1  load strobe to counter (tied 0 without DIRECT_SET_EN).
- SetValue  out  10  BCD load value (tied 0 without DIRECT_SET_EN).

Behaviour:
- Reset (Rst_n=0 at a Clk edge): state IDLE; Busy, Done, Err, Step, Reverse, Set = 0; SetValue = 0; step count = 0. A reset mid-pulse drops Step at that edge. No partial operation resumes.
- BCD to binary: hundreds*100 + tens*10 + ones.
  - A value is invalid if any digit >9, hundreds >2, or the total is >255.
- States: IDLE -> CHECK -> SETUP -> PULSE -> GAP -> CHECK ... -> IDLE.
- IDLE:
  - Req=1 latches Target, clears step count, sets Busy next cycle, goes to CHECK.
  - Req while Busy is ignored. Req held high after Done starts a new operation in the cycle after the return to IDLE.
- CHECK, one clock, compares CntValue (binary c) with the latched target (binary t):
  - Target or CntValue invalid: Err pulse, go to IDLE.
  - c == t: Done pulse, go to IDLE.
  - Step count == STEP_LIMIT: Err pulse, go to IDLE.
  - Otherwise: fwd = (t - c) mod 256. Set Reverse = (fwd > 128); a tie at 128 goes forward. Go to SETUP.
- SETUP: one clock with Step=0, so Reverse is stable a full clock before Step rises.
- PULSE: Step=1 for PULSE_W clocks. Step count increments on entry.
- GAP: Step=0 for GAP_W clocks, then CHECK re-samples CntValue.
- Reverse holds its value between CHECKs. It changes only in CHECK, never while Step=1.
- Busy falls in the same cycle Done or Err is asserted. Done and Err are mutually exclusive.
- Latency: a request already at target gives Done 2 clocks after Req. Each step costs 1 + PULSE_W + GAP_W + 1 clocks.

Optional Feature:
- Macro DIRECT_SET_EN.
- Defined: in the first CHECK of a request, if the shortest distance > SET_THRESHOLD:
  - Set=1 and SetValue=latched Target for PULSE_W clocks (Step stays 0).
  - Then GAP_W clocks, then CHECK. This does not count toward STEP_LIMIT.
  - Later CHECKs always use stepping.
- Undefined: Set and SetValue are tied to 0 and every move is stepped.

Test Plan:
- CntValue=000 (BCD), Target=005 (BCD), Req -> Reverse=0, exactly 5 Step pulses each PULSE_W wide, Done pulse, Busy low.
- Counter model at 10, Target=250 -> Reverse=1, 16 pulses (10->0->255->250), Done, never Err.
- Counter at 0, Target=128 (tie) -> Reverse=0, 128 pulses, Done.
- Target=BCD 260 or tens digit 0xA -> Err 2 clocks after Req, zero Step pulses, Busy low.
- Counter model frozen at 3, Target=9 -> exactly STEP_LIMIT (130) pulses, then Err, no Done.
- Rst_n low during PULSE -> Step, Busy, Reverse = 0 at that edge. A later Req from counter 7 to 7 -> Done with zero pulses. With DIRECT_SET_EN, 0 -> 200: one Set pulse with SetValue=BCD 200, then Done.
